// File: rtl/fsm_ctrl_pkg.sv
// Shared types and defaults for the fsm_controller access arbiter.
// Arbiter state encoding, controller defaults and a width helper.
package fsm_ctrl_pkg;

    localparam int STATE_W_DEF = 3;
    localparam logic [2:0] IDLE_CODE_DEF = 3'b000;

    typedef enum logic [1:0] {
        A_IDLE      = 2'd0,
        A_ISSUE     = 2'd1,
        A_WAIT_BUSY = 2'd2,
        A_WAIT_DONE = 2'd3
    } arb_state_e;

    // Index width that stays at least one bit wide for tiny vectors.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fsm_access_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after the pointer,
// wrapping from N_REQ-1 back to 0.
module rr_pick
    import fsm_ctrl_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int PW    = clog2_min1(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    pointer,
    output logic [N_REQ-1:0] winner,
    output logic [PW-1:0]    winner_idx,
    output logic             valid
);

    logic [PW-1:0]    cand_idx [N_REQ];
    logic [N_REQ-1:0] cand_req;

    // Candidate gi is the requester gi positions after the pointer (mod N_REQ).
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
            logic [PW:0] sum;
            assign sum = {1'b0, pointer} + (PW+1)'(gi);
            assign cand_idx[gi] = (sum >= (PW+1)'(N_REQ)) ? PW'(sum - (PW+1)'(N_REQ))
                                                         : sum[PW-1:0];
            assign cand_req[gi] = req[cand_idx[gi]];
        end
    endgenerate

    always_comb begin
        valid      = 1'b0;
        winner_idx = '0;
        winner     = '0;
        // Scan from the far end so the nearest candidate overwrites the rest.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (cand_req[i]) begin
                valid      = 1'b1;
                winner_idx = cand_idx[i];
            end
        end
        if (valid) begin
            winner[winner_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/fsm_access_arbiter.sv
// Round-robin arbiter sharing one fsm_controller between N_REQ requesters;
// issues one-cycle wr/rd strobes only while the controller sits in IDLE.
module fsm_access_arbiter
    import fsm_ctrl_pkg::*;
#(
    parameter int                 N_REQ     = 4,
    parameter int                 STATE_W   = STATE_W_DEF,
    parameter logic [STATE_W-1:0] IDLE_CODE = STATE_W'(IDLE_CODE_DEF),
    parameter int                 TIMEOUT   = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ-1:0]   req_write,
    input  logic [STATE_W-1:0] fsm_state,
    output logic               fsm_enable,
    output logic               fsm_wr_en,
    output logic               fsm_rd_en,
    output logic [N_REQ-1:0]   grant,
    output logic               done,
    output logic               busy,
    output logic               error
);

    localparam int PW = clog2_min1(N_REQ);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_VAL   = CW'(TIMEOUT);
    localparam logic [PW-1:0] LAST_IDX = PW'(N_REQ - 1);

    arb_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [PW-1:0]    owner_q, owner_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic             wr_en_q, wr_en_d;
    logic             rd_en_q, rd_en_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             error_q, error_d;

    logic [N_REQ-1:0] pick_onehot;
    logic [PW-1:0]    pick_idx;
    logic             pick_valid;

    logic             fsm_idle;
    logic             start;
    logic             advance;
    logic             finish;
    logic             timeout;
    logic [CW-1:0]    cnt_sat;
    logic [PW-1:0]    ptr_next;

    rr_pick #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_rr_pick (
        .req        (req),
        .pointer    (ptr_q),
        .winner     (pick_onehot),
        .winner_idx (pick_idx),
        .valid      (pick_valid)
    );

    assign fsm_idle = (fsm_state == IDLE_CODE);
    assign start    = (state_q == A_IDLE) && enable && pick_valid && fsm_idle;
    assign advance  = (state_q == A_WAIT_BUSY) && !fsm_idle;
    assign finish   = (state_q == A_WAIT_DONE) && fsm_idle;
    assign cnt_sat  = (cnt_q == TO_VAL) ? cnt_q : cnt_q + 1'b1;
    // Progress in a wait state takes priority over an expiring budget.
    assign timeout  = ((state_q == A_WAIT_BUSY) || (state_q == A_WAIT_DONE))
                      && !advance && !finish && (cnt_sat == TO_VAL);
    assign ptr_next = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;

    // State register and all output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= A_IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            owner_q <= '0;
            grant_q <= '0;
            wr_en_q <= 1'b0;
            rd_en_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            grant_q <= grant_d;
            wr_en_q <= wr_en_d;
            rd_en_q <= rd_en_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            error_q <= error_d;
        end
    end

    // Next-state logic, including the timeout counter and rr pointer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        case (state_q)
            A_IDLE: begin
                if (start) begin
                    state_d = A_ISSUE;
                    owner_d = pick_idx;
                end
            end
            A_ISSUE: begin
                state_d = A_WAIT_BUSY;
                cnt_d   = '0;
            end
            A_WAIT_BUSY: begin
                if (advance) begin
                    state_d = A_WAIT_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_sat;
                    if (timeout) begin
                        state_d = A_IDLE;
                        ptr_d   = ptr_next;
                    end
                end
            end
            A_WAIT_DONE: begin
                if (finish) begin
                    state_d = A_IDLE;
                    ptr_d   = ptr_next;
                end else begin
                    cnt_d = cnt_sat;
                    if (timeout) begin
                        state_d = A_IDLE;
                        ptr_d   = ptr_next;
                    end
                end
            end
            default: begin
                state_d = A_IDLE;
            end
        endcase
    end

    // Output logic; values land in registers so every output but fsm_enable is a flop.
    always_comb begin
        grant_d = grant_q;
        wr_en_d = 1'b0;
        rd_en_d = 1'b0;
        done_d  = finish;
        busy_d  = (state_d != A_IDLE);
        error_d = error_q | timeout;
        if (start) begin
            grant_d = pick_onehot;
            wr_en_d = req_write[pick_idx];
            rd_en_d = !req_write[pick_idx];
        end
        if (finish || timeout) begin
            grant_d = '0;
        end
    end

    assign fsm_enable = enable;
    assign fsm_wr_en  = wr_en_q;
    assign fsm_rd_en  = rd_en_q;
    assign grant      = grant_q;
    assign done       = done_q;
    assign busy       = busy_q;
    assign error      = error_q;

endmodule

// File: tb/tb_fsm_access_arbiter.sv
// Scoreboard bench for fsm_access_arbiter with a small behavioural controller model.
module tb_fsm_access_arbiter;

    localparam logic [2:0] IDLE_C = 3'b000;
    localparam logic [2:0] BUSY_C = 3'b011;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic [3:0] req;
    logic [3:0] req_write;
    logic [2:0] fsm_state = IDLE_C;
    logic       fsm_enable, fsm_wr_en, fsm_rd_en, done, busy, error;
    logic [3:0] grant;

    fsm_access_arbiter #(
        .N_REQ     (4),
        .STATE_W   (3),
        .IDLE_CODE (3'b000),
        .TIMEOUT   (16)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .req        (req),
        .req_write  (req_write),
        .fsm_state  (fsm_state),
        .fsm_enable (fsm_enable),
        .fsm_wr_en  (fsm_wr_en),
        .fsm_rd_en  (fsm_rd_en),
        .grant      (grant),
        .done       (done),
        .busy       (busy),
        .error      (error)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [3:0] g;
        logic       wr;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   ptr_m    = 0;
    int   model_len = 3;
    bit   model_force_busy = 1'b0;
    int   mcnt = 0;
    bit   last_idle = 1'b1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick_ref(input logic [3:0] r, input int p);
        for (int i = 0; i < 4; i++) begin
            int k;
            k = (p + i) % 4;
            if (r[k]) return k;
        end
        return -1;
    endfunction

    // Controller model: goes busy on a strobe for model_len cycles, then back to IDLE.
    always @(negedge clock) begin
        if (reset) begin
            fsm_state = IDLE_C;
            mcnt = 0;
        end else if (model_force_busy) begin
            fsm_state = BUSY_C;
        end else if ((fsm_wr_en || fsm_rd_en) && model_len > 0) begin
            fsm_state = BUSY_C;
            mcnt = model_len;
        end else if (mcnt > 0) begin
            mcnt--;
            if (mcnt == 0) fsm_state = IDLE_C;
        end else begin
            fsm_state = IDLE_C;
        end
    end

    always @(posedge clock) last_idle = (fsm_state == IDLE_C);

    // Strobe monitor: invariants plus scoreboard pop.
    always @(negedge clock) begin
        if (!reset && (fsm_wr_en || fsm_rd_en)) begin
            exp_t e;
            check_eq("strobe_exclusive", 32'(fsm_wr_en & fsm_rd_en), 32'd0);
            check_eq("strobe_after_idle", 32'(last_idle), 32'd1);
            if (sb.size() == 0) begin
                check_eq("sb_unexpected_strobe", 32'({fsm_wr_en, fsm_rd_en}), 32'd0);
            end else begin
                e = sb.pop_front();
                check_eq("sb_grant", 32'(grant), 32'(e.g));
                check_eq("sb_wr_en", 32'(fsm_wr_en), 32'(e.wr));
                check_eq("sb_rd_en", 32'(fsm_rd_en), 32'(!e.wr));
                $display("txn grant=%b wr=%0b rd=%0b t=%0t", grant, fsm_wr_en, fsm_rd_en, $time);
            end
        end
    end

    task automatic push_expect(input logic [3:0] r, input logic [3:0] w, input int len);
        int k;
        exp_t e;
        req = r;
        req_write = w;
        model_len = len;
        k = pick_ref(r, ptr_m);
        if (k >= 0) begin
            e.g = 4'(1 << k);
            e.wr = w[k];
            sb.push_back(e);
            ptr_m = (k + 1) % 4;
        end
    endtask

    task automatic wait_strobe(input string tag, input int exp_lat);
        int lat = 0;
        do begin
            @(negedge clock);
            lat++;
        end while (!(fsm_wr_en || fsm_rd_en) && lat < 40);
        if (fsm_wr_en || fsm_rd_en) begin
            if (exp_lat > 0) check_eq({tag, "_strobe_lat"}, 32'(lat), 32'(exp_lat));
        end else begin
            check_eq({tag, "_strobe_seen"}, 32'(fsm_wr_en | fsm_rd_en), 32'd1);
        end
    endtask

    task automatic wait_done(input string tag, input int exp_lat);
        int lat = 0;
        do begin
            @(negedge clock);
            lat++;
        end while (!done && lat < 40);
        if (done) begin
            check_eq({tag, "_done_lat"}, 32'(lat), 32'(exp_lat));
            check_eq({tag, "_done_grant"}, 32'(grant), 32'd0);
            check_eq({tag, "_done_busy"}, 32'(busy), 32'd0);
        end else begin
            check_eq({tag, "_done_seen"}, 32'(done), 32'd1);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        ptr_m = 0;
    endtask

    initial begin
        logic [3:0] order [5];
        bit done_seen;
        order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
        order[3] = 4'b1000; order[4] = 4'b0001;
        reset = 1'b1;
        enable = 1'b1;
        req = 4'b0000;
        req_write = 4'b0000;

        @(negedge clock);
        check_eq("rst_grant", 32'(grant), 32'd0);
        check_eq("rst_strobes", 32'({fsm_wr_en, fsm_rd_en}), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_error", 32'(error), 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // 1: single write from requester 1, then pointer should sit at 2.
        push_expect(4'b0010, 4'b0010, 3);
        wait_strobe("t1", 1);
        check_eq("t1_grant", 32'(grant), 32'b0010);
        check_eq("t1_wr_en", 32'(fsm_wr_en), 32'd1);
        check_eq("t1_busy", 32'(busy), 32'd1);
        req = 4'b0000;
        @(negedge clock);
        check_eq("t1_strobe_one_cycle", 32'({fsm_wr_en, fsm_rd_en}), 32'd0);
        wait_done("t1", 3);
        @(negedge clock);
        check_eq("t1_done_pulse", 32'(done), 32'd0);
        push_expect(4'b1111, 4'b0000, 3);
        wait_strobe("t1p", 1);
        check_eq("t1_ptr_grant", 32'(grant), 32'b0100);
        req = 4'b0000;
        wait_done("t1p", 4);
        do_reset();

        // 2: all requesting, round-robin order with wrap.
        for (int i = 0; i < 5; i++) begin
            push_expect(4'b1111, 4'b0101, 3);
            wait_strobe("t2", 1);
            check_eq("t2_order", 32'(grant), 32'(order[i]));
            wait_done("t2", 4);
        end
        req = 4'b0000;
        @(negedge clock);

        // 3: controller not IDLE, request must wait.
        model_force_busy = 1'b1;
        @(negedge clock);
        push_expect(4'b0001, 4'b0000, 3);
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            check_eq("t3_hold_grant", 32'(grant), 32'd0);
        end
        model_force_busy = 1'b0;
        wait_strobe("t3", 0);
        check_eq("t3_grant", 32'(grant), 32'b0001);
        req = 4'b0000;
        wait_done("t3", 4);

        // 4: controller never leaves IDLE -> timeout after 16 cycles in WAIT_BUSY.
        push_expect(4'b0100, 4'b0000, 0);
        wait_strobe("t4", 1);
        req = 4'b0000;
        done_seen = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clock);
            done_seen |= done;
        end
        check_eq("t4_error_early", 32'(error), 32'd0);
        @(negedge clock);
        done_seen |= done;
        check_eq("t4_error", 32'(error), 32'd1);
        check_eq("t4_grant", 32'(grant), 32'd0);
        check_eq("t4_busy", 32'(busy), 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            done_seen |= done;
        end
        check_eq("t4_no_done", 32'(done_seen), 32'd0);
        check_eq("t4_error_sticky", 32'(error), 32'd1);

        // 5: asynchronous reset while waiting for the controller to finish.
        push_expect(4'b1000, 4'b1000, 10);
        wait_strobe("t5", 1);
        check_eq("t5_grant", 32'(grant), 32'b1000);
        for (int k = 0; k < 3; k++) @(negedge clock);
        check_eq("t5_busy_pre", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check_eq("t5_rst_grant", 32'(grant), 32'd0);
        check_eq("t5_rst_strobes", 32'({fsm_wr_en, fsm_rd_en}), 32'd0);
        check_eq("t5_rst_busy", 32'(busy), 32'd0);
        check_eq("t5_rst_error", 32'(error), 32'd0);
        @(negedge clock);
        @(negedge clock);
        check_eq("t5_sb_empty", 32'(sb.size()), 32'd0);
        ptr_m = 0;
        reset = 1'b0;
        push_expect(4'b1111, 4'b0000, 3);
        wait_strobe("t5r", 1);
        check_eq("t5_after_rst_grant", 32'(grant), 32'b0001);
        wait_done("t5r", 4);

        // 6: enable dropped during WAIT_BUSY; in-flight completes, nothing new.
        push_expect(4'b1111, 4'b1111, 3);
        wait_strobe("t6", 1);
        check_eq("t6_grant", 32'(grant), 32'b0010);
        @(negedge clock);
        enable = 1'b0;
        #1;
        check_eq("t6_fsm_enable", 32'(fsm_enable), 32'd0);
        wait_done("t6", 3);
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            check_eq("t6_no_grant", 32'(grant), 32'd0);
        end
        push_expect(4'b1111, 4'b0000, 3);
        enable = 1'b1;
        wait_strobe("t6e", 1);
        check_eq("t6_resume_grant", 32'(grant), 32'b0100);
        req = 4'b0000;
        wait_done("t6e", 4);
        check_eq("t6_error_clear", 32'(error), 32'd0);
        repeat (3) @(negedge clock);
        check_eq("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its end, %0d checks so far", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
